// File: rtl/instr_issue_unit.sv
// Issue stage: circular instruction FIFO feeding the ALU/memory pipeline, one decoded word per cycle.
// Optional RAW interlock (history, STALL state, stall_cnt) is enabled by defining HAZARD_INTERLOCK_EN.
module instr_issue_unit #(
    parameter int DEPTH      = 8,
    parameter int HAZ_WINDOW = 2
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [23:0]              wr_instr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     issue_en,
    output logic                     issue_valid,
    output logic [3:0]               func,
    output logic [3:0]               rd,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [7:0]               addr,
    output logic [1:0]               state,
    output logic [7:0]               stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || HAZ_WINDOW < 1 || HAZ_WINDOW > 3)
    begin : g_param_check
        $error("instr_issue_unit: unsupported DEPTH or HAZ_WINDOW");
    end

    logic [23:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [23:0]   head_s;
    logic          hazard_s;
    logic          push_s;
    logic          pop_s;
    logic          issue_valid_r;
    logic [23:0]   out_r;

    assign head_s = mem_r[rd_ptr_r];
    // Write acceptance uses only the registered full flag, so a pop never frees room in the same cycle.
    assign push_s = wr_en & ~full_r;
    assign pop_s  = issue_en & ~empty_r & ~hazard_s;

`ifdef HAZARD_INTERLOCK_EN
    logic [HAZ_WINDOW-1:0] hist_v_r;
    logic [3:0]            hist_rd_r [HAZ_WINDOW];
    logic [7:0]            stall_cnt_r;
    logic                  stall_cyc_s;

    assign stall_cyc_s = issue_en & ~empty_r & hazard_s;

    // RAW check of the head's sources against every valid destination still in flight.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++) begin
            hazard_s = hazard_s | (hist_v_r[i] & ((hist_rd_r[i] == head_s[15:12]) |
                                                  (hist_rd_r[i] == head_s[11:8])));
        end
        hazard_s = hazard_s & ~empty_r;
    end

    // History shifts every cycle; bubbles enter as invalid entries.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            hist_v_r <= {HAZ_WINDOW{1'b0}};
            for (int i = 0; i < HAZ_WINDOW; i++) hist_rd_r[i] <= 4'd0;
        end else begin
            for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
                hist_v_r[i]  <= hist_v_r[i-1];
                hist_rd_r[i] <= hist_rd_r[i-1];
            end
            hist_v_r[0]  <= pop_s;
            hist_rd_r[0] <= pop_s ? head_s[19:16] : 4'd0;
        end
    end

    // Saturating count of cycles lost to hazards.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 8'd0;
        end else if (stall_cyc_s && stall_cnt_r != 8'hFF) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign hazard_s  = 1'b0;
    assign stall_cnt = 8'd0;
`endif

    // Storage array; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk1) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_instr;
        end
    end

    // Occupancy after this edge's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers and flags; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Issue register: head fields on a pop, all-zero bubble otherwise.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            issue_valid_r <= 1'b0;
            out_r         <= 24'd0;
        end else begin
            issue_valid_r <= pop_s;
            out_r         <= pop_s ? head_s : 24'd0;
        end
    end

    // Run-gate / stall sequencing.
    always_comb begin
        state_nxt_s = state_r;
        if (!issue_en) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = RUN;
                RUN:     state_nxt_s = (~empty_r & hazard_s) ? STALL : RUN;
                STALL:   state_nxt_s = hazard_s ? STALL : RUN;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    assign full        = full_r;
    assign empty       = empty_r;
    assign count       = count_r;
    assign issue_valid = issue_valid_r;
    assign func        = out_r[23:20];
    assign rd          = out_r[19:16];
    assign rs1         = out_r[15:12];
    assign rs2         = out_r[11:8];
    assign addr        = out_r[7:0];
    assign state       = state_r;
endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_instr_issue_unit;
    localparam int DEPTH = 8;
    localparam int HW    = 2;
`ifdef HAZARD_INTERLOCK_EN
    localparam bit INTERLOCK = 1'b1;
`else
    localparam bit INTERLOCK = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [23:0] wr_instr;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        issue_en;
    logic        issue_valid;
    logic [3:0]  func, rd, rs1, rs2;
    logic [7:0]  addr;
    logic [1:0]  state;
    logic [7:0]  stall_cnt;

    instr_issue_unit #(.DEPTH(DEPTH), .HAZ_WINDOW(HW)) dut (
        .clk1(clk1), .rst(rst), .wr_en(wr_en), .wr_instr(wr_instr),
        .full(full), .empty(empty), .count(count), .issue_en(issue_en),
        .issue_valid(issue_valid), .func(func), .rd(rd), .rs1(rs1), .rs2(rs2),
        .addr(addr), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Reference model: a queue of words plus a record of the last HW issue slots.
    logic [23:0] mq[$];
    bit          hv[HW];
    logic [3:0]  hr[HW];
    bit          m_valid;
    logic [23:0] m_out;
    int          m_state;
    int          m_stall;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < HW; i++) begin hv[i] = 1'b0; hr[i] = 4'd0; end
        m_valid = 1'b0; m_out = 24'd0; m_state = 0; m_stall = 0;
    endfunction

    function automatic void model_edge(input bit w, input logic [23:0] ins, input bit ie);
        bit          hz = 1'b0;
        bit          pop;
        bit          was_full = (mq.size() == DEPTH);
        logic [23:0] head = (mq.size() > 0) ? mq[0] : 24'd0;
        if (INTERLOCK && mq.size() > 0)
            for (int i = 0; i < HW; i++)
                if (hv[i] && (hr[i] == head[15:12] || hr[i] == head[11:8])) hz = 1'b1;
        pop = ie && (mq.size() > 0) && !hz;
        if (!ie)               m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1) m_state = (mq.size() > 0 && hz) ? 2 : 1;
        else                   m_state = hz ? 2 : 1;
        if (ie && mq.size() > 0 && hz && m_stall < 255) m_stall++;
        for (int i = HW - 1; i > 0; i--) begin hv[i] = hv[i-1]; hr[i] = hr[i-1]; end
        hv[0] = pop; hr[0] = head[19:16];
        m_valid = pop;
        m_out   = pop ? mq.pop_front() : 24'd0;
        if (w && !was_full) mq.push_back(ins);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"},     issue_valid, m_valid);
        chk({tag, ".fields"},    {func, rd, rs1, rs2, addr}, m_out);
        chk({tag, ".count"},     count, mq.size());
        chk({tag, ".full"},      full, (mq.size() == DEPTH));
        chk({tag, ".empty"},     empty, (mq.size() == 0));
        chk({tag, ".state"},     state, m_state);
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    endtask

    task automatic step(input string tag, input bit w, input logic [23:0] ins, input bit ie);
        wr_en = w; wr_instr = ins; issue_en = ie;
        model_edge(w, ins, ie);
        @(posedge clk1);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit          w;
        logic [23:0] ins;
        bit          ie;
        bit          ev;
        logic [23:0] eo;
        int          est;
        int          ecnt;
        int          estall;
    } vec_t;

    function automatic vec_t mk(input bit w, input logic [23:0] ins, input bit ie, input bit ev,
                                input logic [23:0] eo, input int est, input int ecnt, input int estall);
        vec_t v;
        v.w = w; v.ins = ins; v.ie = ie; v.ev = ev; v.eo = eo;
        v.est = est; v.ecnt = ecnt; v.estall = estall;
        return v;
    endfunction

    function automatic logic [23:0] wd(input int i);
        return {4'(i), 4'hF, 4'h1, 4'h2, 8'(i)};
    endfunction

    localparam logic [23:0] WA = 24'h1A357D;  // {1,10,3,5,125}
    localparam logic [23:0] WB = 24'h2C387E;  // {2,12,3,8,126}
    localparam logic [23:0] WC = 24'h3E7580;  // {3,14,7,5,128}
    localparam logic [23:0] WQ = 24'h3EA580;  // {3,14,10,5,128}, reads rd of WA

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(1'b1, WA, 1'b0, 1'b0, 24'd0, 0, 1, 0);
        tbl[1]  = mk(1'b1, WB, 1'b0, 1'b0, 24'd0, 0, 2, 0);
        tbl[2]  = mk(1'b1, WC, 1'b0, 1'b0, 24'd0, 0, 3, 0);
        tbl[3]  = mk(1'b0, 24'd0, 1'b1, 1'b1, WA, 1, 2, 0);
        tbl[4]  = mk(1'b0, 24'd0, 1'b1, 1'b1, WB, 1, 1, 0);
        tbl[5]  = mk(1'b0, 24'd0, 1'b1, 1'b1, WC, 1, 0, 0);
        tbl[6]  = mk(1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 1, 0, 0);
        tbl[7]  = mk(1'b1, WA, 1'b1, 1'b0, 24'd0, 1, 1, 0);
        tbl[8]  = mk(1'b1, WQ, 1'b1, 1'b1, WA, 1, 1, 0);
`ifdef HAZARD_INTERLOCK_EN
        tbl[9]  = mk(1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 2, 1, 1);
        tbl[10] = mk(1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 2, 1, 2);
        tbl[11] = mk(1'b0, 24'd0, 1'b1, 1'b1, WQ, 1, 0, 2);
        tbl[12] = mk(1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 0, 0, 2);
`else
        tbl[9]  = mk(1'b0, 24'd0, 1'b1, 1'b1, WQ, 1, 0, 0);
        tbl[10] = mk(1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 1, 0, 0);
        tbl[11] = mk(1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 1, 0, 0);
        tbl[12] = mk(1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 0, 0, 0);
`endif

        rst = 1'b1; wr_en = 1'b0; wr_instr = 24'd0; issue_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Independent stream, dependent pair, then run gate dropped.
        for (int i = 0; i < 13; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].w, tbl[i].ins, tbl[i].ie);
            chk($sformatf("tbl%0d.exp_valid", i), issue_valid, tbl[i].ev);
            chk($sformatf("tbl%0d.exp_fields", i), {func, rd, rs1, rs2, addr}, tbl[i].eo);
            chk($sformatf("tbl%0d.exp_state", i), state, tbl[i].est);
            chk($sformatf("tbl%0d.exp_count", i), count, tbl[i].ecnt);
            chk($sformatf("tbl%0d.exp_stall", i), stall_cnt, tbl[i].estall);
        end

        // Reset mid-stream with words queued and an instruction on the outputs.
        step("mr_w0", 1'b1, WA, 1'b0);
        step("mr_w1", 1'b1, WB, 1'b0);
        step("mr_w2", 1'b1, WC, 1'b0);
        step("mr_pop", 1'b1, wd(7), 1'b1);
        wr_en = 1'b0; issue_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.count", count, 0);
        chk("async_rst.empty", empty, 1);
        chk("async_rst.valid", issue_valid, 0);
        chk("async_rst.state", state, 0);
        chk("async_rst.fields", {func, rd, rs1, rs2, addr}, 0);
        @(posedge clk1);
        #1;
        check_all("rst_hold");
        rst = 1'b0;

        // Fill past capacity with the run gate low, then drain across the pointer wrap.
        for (int i = 0; i < 9; i++) step($sformatf("fill%0d", i), 1'b1, wd(i), 1'b0);
        chk("fill.full", full, 1);
        chk("fill.count", count, DEPTH);
        for (int k = 0; k < 8; k++) begin
            step($sformatf("wrap%0d", k), (k >= 1 && k <= 4), wd(100 + k), 1'b1);
            if (k == 0) chk("wrap.first_word", {func, rd, rs1, rs2, addr}, wd(0));
        end
        for (int k = 0; k < 6; k++) step($sformatf("drain%0d", k), 1'b0, 24'd0, 1'b1);
        chk("drain.empty", empty, 1);

        // Simultaneous push and pop with a single entry queued.
        step("pp_load", 1'b1, wd(40), 1'b0);
        step("pp_both", 1'b1, wd(41), 1'b1);
        chk("pp.count", count, 1);
        chk("pp.word", {func, rd, rs1, rs2, addr}, wd(40));
        step("pp_tail", 1'b0, 24'd0, 1'b1);
        chk("pp.tail_word", {func, rd, rs1, rs2, addr}, wd(41));

        // Random traffic with a narrow register range so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            logic [23:0] r_ins;
            r_ins = {4'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom),
                     2'b00, 2'($urandom), 8'($urandom)};
            step($sformatf("rnd%0d", n), ($urandom_range(0, 9) < 6), r_ins,
                 ($urandom_range(0, 9) < 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
